access_sequencer: RTL and testbench

Sequencing controller for the door lock. It consumes the result of each password attempt (user or master match) and drives the lock actuator. It also counts consecutive failures, enforces a timed lockout, re-locks automatically after a hold time, and clears the input buffer after every attempt. It sits between the comparator outputs and the `locked` output of the door-lock top.

---
 rtl/doorlock_pkg.sv | 20 ++
 rtl/dl_timer.sv | 39 +++
 rtl/access_sequencer.sv | 177 +++++++++++++++++
 tb/tb_access_sequencer.sv | 169 ++++++++++++++++
 4 files changed

// File: rtl/doorlock_pkg.sv
// Shared door-lock definitions: sequencer state encoding and default cycle constants
// for every door-lock block.
package doorlock_pkg;

    localparam logic [1:0] LOCKED   = 2'd0;
    localparam logic [1:0] UNLOCKED = 2'd1;
    localparam logic [1:0] LOCKOUT  = 2'd2;

    typedef enum logic [1:0] {
        S_LOCKED   = LOCKED,
        S_UNLOCKED = UNLOCKED,
        S_LOCKOUT  = LOCKOUT
    } dl_state_e;

    localparam int DEF_MAX_FAILS      = 3;
    localparam int DEF_UNLOCK_CYCLES  = 500;
    localparam int DEF_LOCKOUT_CYCLES = 1000;
    localparam int DEF_CNT_W          = 16;

endpackage

// File: rtl/dl_timer.sv
// Load/decrement countdown with a zero flag; shared by the timed door-lock states.
module dl_timer #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             load_i,
    input  logic [CNT_W-1:0] load_val_i,
    input  logic             dec_i,
    output logic             zero_o
);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    // Next count: load wins over decrement, decrement stops at zero
    always_comb begin
        cnt_d = cnt_q;
        if (load_i) begin
            cnt_d = load_val_i;
        end else if (dec_i && (cnt_q != {CNT_W{1'b0}})) begin
            cnt_d = cnt_q - {{(CNT_W-1){1'b0}}, 1'b1};
        end else begin
            cnt_d = cnt_q;
        end
    end

    // Count register
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            cnt_q <= {CNT_W{1'b0}};
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign zero_o = (cnt_q == {CNT_W{1'b0}});

endmodule

// File: rtl/access_sequencer.sv
// Door-lock sequencing FSM: fail counting, timed lockout and auto-relock.
// Optional tamper alarm flop enabled by DOORLOCK_ALARM_EN.
module access_sequencer
    import doorlock_pkg::*;
#(
    parameter int MAX_FAILS      = DEF_MAX_FAILS,
    parameter int UNLOCK_CYCLES  = DEF_UNLOCK_CYCLES,
    parameter int LOCKOUT_CYCLES = DEF_LOCKOUT_CYCLES,
    parameter int CNT_W          = DEF_CNT_W
) (
    input  logic       clk,
    input  logic       rstn,
    input  logic       attempt_valid_i,
    input  logic       match_i,
    input  logic       master_match_i,
    input  logic       relock_i,
    output logic       locked_o,
    output logic       lockout_o,
    output logic       accept_o,
    output logic       buff_rst_o,
    output logic [3:0] fail_count_o,
    output logic       alarm_o
);

    localparam logic [3:0]       MAX_FAILS_C    = 4'(MAX_FAILS);
    localparam logic [CNT_W-1:0] UNLOCK_LOAD_C  = CNT_W'(UNLOCK_CYCLES - 1);
    localparam logic [CNT_W-1:0] LOCKOUT_LOAD_C = CNT_W'(LOCKOUT_CYCLES - 1);

    dl_state_e        state_q;
    dl_state_e        state_d;
    logic [3:0]       fail_q;
    logic [3:0]       fail_d;
    logic [3:0]       fail_inc_s;
    logic             locked_q;
    logic             lockout_q;
    logic             accept_q;
    logic             buff_rst_q;
    logic             tmr_load_s;
    logic [CNT_W-1:0] tmr_val_s;
    logic             tmr_dec_s;
    logic             tmr_zero_s;

    assign fail_inc_s = fail_q + 4'd1;

    dl_timer #(
        .CNT_W (CNT_W)
    ) u_timer (
        .clk        (clk),
        .rstn       (rstn),
        .load_i     (tmr_load_s),
        .load_val_i (tmr_val_s),
        .dec_i      (tmr_dec_s),
        .zero_o     (tmr_zero_s)
    );

    // Next-state, fail-count and timer-decrement decisions
    always_comb begin
        state_d   = state_q;
        fail_d    = fail_q;
        tmr_dec_s = 1'b0;
        case (state_q)
            S_LOCKED: begin
                if (attempt_valid_i) begin
                    if (master_match_i || match_i) begin
                        state_d = S_UNLOCKED;
                        fail_d  = 4'd0;
                    end else if (fail_inc_s == MAX_FAILS_C) begin
                        state_d = S_LOCKOUT;
                        fail_d  = MAX_FAILS_C;
                    end else begin
                        fail_d  = fail_inc_s;
                    end
                end else begin
                    state_d = S_LOCKED;
                end
            end
            S_UNLOCKED: begin
                if (tmr_zero_s || relock_i) begin
                    state_d = S_LOCKED;
                end else begin
                    tmr_dec_s = 1'b1;
                end
            end
            S_LOCKOUT: begin
                // A master attempt on the expiry edge still unlocks
                if (attempt_valid_i && master_match_i) begin
                    state_d = S_UNLOCKED;
                    fail_d  = 4'd0;
                end else if (tmr_zero_s) begin
                    state_d = S_LOCKED;
                    fail_d  = 4'd0;
                end else begin
                    tmr_dec_s = 1'b1;
                end
            end
            default: begin
                state_d = S_LOCKED;
                fail_d  = 4'd0;
            end
        endcase
    end

    // Timer load on every state change; returning to LOCKED forces it to zero
    always_comb begin
        tmr_load_s = 1'b0;
        tmr_val_s  = {CNT_W{1'b0}};
        if (state_d != state_q) begin
            tmr_load_s = 1'b1;
            case (state_d)
                S_UNLOCKED: tmr_val_s = UNLOCK_LOAD_C;
                S_LOCKOUT:  tmr_val_s = LOCKOUT_LOAD_C;
                default:    tmr_val_s = {CNT_W{1'b0}};
            endcase
        end else begin
            tmr_load_s = 1'b0;
        end
    end

    // State, counter and registered output flops
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q    <= S_LOCKED;
            fail_q     <= 4'd0;
            locked_q   <= 1'b1;
            lockout_q  <= 1'b0;
            accept_q   <= 1'b1;
            buff_rst_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            fail_q     <= fail_d;
            locked_q   <= (state_d != S_UNLOCKED);
            lockout_q  <= (state_d == S_LOCKOUT);
            accept_q   <= (state_d == S_LOCKED);
            buff_rst_q <= attempt_valid_i;
        end
    end

    assign locked_o     = locked_q;
    assign lockout_o    = lockout_q;
    assign accept_o     = accept_q;
    assign buff_rst_o   = buff_rst_q;
    assign fail_count_o = fail_q;

`ifdef DOORLOCK_ALARM_EN
    logic alarm_q;
    logic alarm_d;
    logic master_ok_s;

    assign master_ok_s = attempt_valid_i && master_match_i && (state_q != S_UNLOCKED);

    // Alarm: set entering lockout, cleared only by an accepted master attempt
    always_comb begin
        alarm_d = alarm_q;
        if ((state_d == S_LOCKOUT) && (state_q != S_LOCKOUT)) begin
            alarm_d = 1'b1;
        end else if (master_ok_s) begin
            alarm_d = 1'b0;
        end else begin
            alarm_d = alarm_q;
        end
    end

    // Alarm flop
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            alarm_q <= 1'b0;
        end else begin
            alarm_q <= alarm_d;
        end
    end

    assign alarm_o = alarm_q;
`else
    assign alarm_o = 1'b0;
`endif

endmodule

// File: tb/tb_access_sequencer.sv
// Directed self-checking bench for access_sequencer (MAX_FAILS=3, UNLOCK=5, LOCKOUT=8).
module tb_access_sequencer;

    logic       clk;
    logic       rstn;
    logic       attempt_valid_i;
    logic       match_i;
    logic       master_match_i;
    logic       relock_i;
    logic       locked_o;
    logic       lockout_o;
    logic       accept_o;
    logic       buff_rst_o;
    logic [3:0] fail_count_o;
    logic       alarm_o;

    int n_vec;
    int n_bad;

`ifdef DOORLOCK_ALARM_EN
    localparam logic ALM_ON = 1'b1;
`else
    localparam logic ALM_ON = 1'b0;
`endif

    access_sequencer #(
        .MAX_FAILS      (3),
        .UNLOCK_CYCLES  (5),
        .LOCKOUT_CYCLES (8),
        .CNT_W          (16)
    ) dut (
        .clk             (clk),
        .rstn            (rstn),
        .attempt_valid_i (attempt_valid_i),
        .match_i         (match_i),
        .master_match_i  (master_match_i),
        .relock_i        (relock_i),
        .locked_o        (locked_o),
        .lockout_o       (lockout_o),
        .accept_o        (accept_o),
        .buff_rst_o      (buff_rst_o),
        .fail_count_o    (fail_count_o),
        .alarm_o         (alarm_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [3:0] obs, input logic [3:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Checks every output against expected: locked, lockout, accept, buff_rst, fails, alarm
    task automatic chk_all(input string tag, input logic lk, input logic lo, input logic ac,
                           input logic br, input logic [3:0] fc, input logic al);
        chk({tag, ".locked"},   {3'd0, locked_o},   {3'd0, lk});
        chk({tag, ".lockout"},  {3'd0, lockout_o},  {3'd0, lo});
        chk({tag, ".accept"},   {3'd0, accept_o},   {3'd0, ac});
        chk({tag, ".buff_rst"}, {3'd0, buff_rst_o}, {3'd0, br});
        chk({tag, ".fails"},    fail_count_o,       fc);
        chk({tag, ".alarm"},    {3'd0, alarm_o},    {3'd0, al});
    endtask

    task automatic cyc(input int n);
        for (int i = 0; i < n; i++) @(negedge clk);
    endtask

    // Present one attempt sampled on the next rising edge; returns at the following negedge
    task automatic attempt(input logic m, input logic mm);
        attempt_valid_i = 1'b1;
        match_i         = m;
        master_match_i  = mm;
        @(negedge clk);
        attempt_valid_i = 1'b0;
        match_i         = 1'b0;
        master_match_i  = 1'b0;
    endtask

    initial begin
        n_vec = 0;
        n_bad = 0;
        rstn = 1'b0;
        attempt_valid_i = 1'b0;
        match_i = 1'b0;
        master_match_i = 1'b0;
        relock_i = 1'b0;
        cyc(3);
        chk_all("reset", 1'b1, 1'b0, 1'b1, 1'b0, 4'd0, 1'b0);
        rstn = 1'b1;
        cyc(1);
        chk_all("idle", 1'b1, 1'b0, 1'b1, 1'b0, 4'd0, 1'b0);

        // Correct attempt: unlocked for exactly 5 cycles, single buff_rst pulse
        attempt(1'b1, 1'b0);
        chk_all("unl_c1", 1'b0, 1'b0, 1'b0, 1'b1, 4'd0, 1'b0);
        attempt(1'b0, 1'b0);
        chk_all("unl_c2_ignored", 1'b0, 1'b0, 1'b0, 1'b1, 4'd0, 1'b0);
        cyc(1);
        chk_all("unl_c3", 1'b0, 1'b0, 1'b0, 1'b0, 4'd0, 1'b0);
        cyc(2);
        chk("unl_c5.locked", {3'd0, locked_o}, 4'd0);
        cyc(1);
        chk_all("relocked", 1'b1, 1'b0, 1'b1, 1'b0, 4'd0, 1'b0);

        // Two wrong attempts then a correct one
        attempt(1'b0, 1'b0);
        chk_all("wrong1", 1'b1, 1'b0, 1'b1, 1'b1, 4'd1, 1'b0);
        attempt(1'b0, 1'b0);
        chk_all("wrong2", 1'b1, 1'b0, 1'b1, 1'b1, 4'd2, 1'b0);
        attempt(1'b1, 1'b0);
        chk_all("right3", 1'b0, 1'b0, 1'b0, 1'b1, 4'd0, 1'b0);
        cyc(5);
        chk("right3_relock.locked", {3'd0, locked_o}, 4'd1);

        // Three back-to-back wrong attempts: lockout for 8 cycles
        attempt(1'b0, 1'b0);
        attempt(1'b0, 1'b0);
        chk("b2b.fails", fail_count_o, 4'd2);
        attempt(1'b0, 1'b0);
        chk_all("lo_c1", 1'b1, 1'b1, 1'b0, 1'b1, 4'd3, ALM_ON);
        attempt(1'b0, 1'b0);
        chk_all("lo_c2_drop", 1'b1, 1'b1, 1'b0, 1'b1, 4'd3, ALM_ON);
        cyc(6);
        chk_all("lo_c8", 1'b1, 1'b1, 1'b0, 1'b0, 4'd3, ALM_ON);
        cyc(1);
        chk_all("lo_expired", 1'b1, 1'b0, 1'b1, 1'b0, 4'd0, ALM_ON);

        // Lockout, then master attempt during lockout cycle 4
        attempt(1'b0, 1'b0);
        attempt(1'b0, 1'b0);
        attempt(1'b0, 1'b0);
        chk_all("lo2_c1", 1'b1, 1'b1, 1'b0, 1'b1, 4'd3, ALM_ON);
        cyc(3);
        chk_all("lo2_c4", 1'b1, 1'b1, 1'b0, 1'b0, 4'd3, ALM_ON);
        attempt(1'b1, 1'b1);
        chk_all("master_unl", 1'b0, 1'b0, 1'b0, 1'b1, 4'd0, 1'b0);

        // Relock request during unlock cycle 2
        cyc(1);
        chk("relock_c2.locked", {3'd0, locked_o}, 4'd0);
        relock_i = 1'b1;
        cyc(1);
        relock_i = 1'b0;
        chk_all("relock_done", 1'b1, 1'b0, 1'b1, 1'b0, 4'd0, 1'b0);

        // Asynchronous reset during lockout cycle 3
        attempt(1'b0, 1'b0);
        attempt(1'b0, 1'b0);
        attempt(1'b0, 1'b0);
        cyc(2);
        chk_all("lo3_c3", 1'b1, 1'b1, 1'b0, 1'b0, 4'd3, ALM_ON);
        #2;
        rstn = 1'b0;
        #1;
        chk_all("async_rst", 1'b1, 1'b0, 1'b1, 1'b0, 4'd0, 1'b0);
        cyc(1);
        rstn = 1'b1;
        cyc(2);
        chk_all("post_rst", 1'b1, 1'b0, 1'b1, 1'b0, 4'd0, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
